// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared types and constants for the two-port RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int TIMEOUT_DEF = 16;
    localparam int TO_W        = $clog2(TIMEOUT_DEF);
    localparam int BE_W_DEF    = 4;
    localparam logic [BE_W_DEF-1:0] BE_ALL = '1;

    // Width of a counter that must reach timeout-1.
    function automatic int to_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Fetch, data and RAM handshake signals seen by the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_err;

    logic              ram_req;
    logic              ram_we;
    logic [BE_W-1:0]   ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ready;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_done, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_done, d_err,
        output ram_req, ram_we, ram_be, ram_addr, ram_wdata,
        input  ram_rdata, ram_ready
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_done, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_done, d_err,
        input  ram_req, ram_we, ram_be, ram_addr, ram_wdata,
        output ram_rdata, ram_ready
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-input round-robin grant with a last-grant register.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_req_f,
    input  wire logic i_req_d,
    input  wire logic i_update,
    output logic      o_grant,
    output logic      o_valid
);

    logic r_last;

    // On a tie the port that did not win last time is favoured.
    always_comb begin
        o_valid = i_req_f | i_req_d;
        if (i_req_f && i_req_d) begin
            o_grant = ~r_last;
        end else if (i_req_d) begin
            o_grant = OWN_D;
        end else begin
            o_grant = OWN_I;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= OWN_I;
        end else if (i_update && o_valid) begin
            r_last <= o_grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares one RAM port between fetch and load/store with timeout.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input wire logic     clk,
    input wire logic     rst,
    mem_arbiter_if.slave bus
);

    localparam int c_be_w  = DATA_W / 8;
    localparam int c_cnt_w = to_width(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_owner;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_ram_req;
    logic                r_ram_we;
    logic [c_be_w-1:0]   r_ram_be;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic [DATA_W-1:0]   r_i_rdata;
    logic                r_i_done;
    logic                r_i_err;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_d_done;
    logic                r_d_err;

    logic w_grant;
    logic w_valid;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .i_req_f  (bus.i_req),
        .i_req_d  (bus.d_req),
        .i_update (r_state == IDLE),
        .o_grant  (w_grant),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_I;
            r_cnt       <= '0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_be    <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_i_rdata   <= '0;
            r_i_done    <= 1'b0;
            r_i_err     <= 1'b0;
            r_d_rdata   <= '0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner   <= w_grant;
                        r_ram_req <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= BUSY;
                        if (w_grant == OWN_D) begin
                            r_ram_we    <= bus.d_we;
                            r_ram_be    <= bus.d_be;
                            r_ram_addr  <= bus.d_addr;
                            r_ram_wdata <= bus.d_wdata;
                        end else begin
                            r_ram_we    <= 1'b0;
                            r_ram_be    <= '1;
                            r_ram_addr  <= bus.i_addr;
                            r_ram_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.ram_ready) begin
                        r_ram_req <= 1'b0;
                        r_state   <= DONE;
                        if (r_owner == OWN_D) begin
                            r_d_done  <= 1'b1;
                            r_d_err   <= 1'b0;
                            r_d_rdata <= r_ram_we ? '0 : bus.ram_rdata;
                        end else begin
                            r_i_done  <= 1'b1;
                            r_i_err   <= 1'b0;
                            r_i_rdata <= bus.ram_rdata;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        // RAM never answered: abort with an error completion.
                        r_ram_req <= 1'b0;
                        r_state   <= DONE;
                        if (r_owner == OWN_D) begin
                            r_d_done  <= 1'b1;
                            r_d_err   <= 1'b1;
                            r_d_rdata <= '0;
                        end else begin
                            r_i_done  <= 1'b1;
                            r_i_err   <= 1'b1;
                            r_i_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_i_done    <= 1'b0;
                    r_i_err     <= 1'b0;
                    r_d_done    <= 1'b0;
                    r_d_err     <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_ram_be    <= '0;
                    r_ram_addr  <= '0;
                    r_ram_wdata <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ram_req   = r_ram_req;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_be    = r_ram_be;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.i_done    = r_i_done;
    assign bus.i_err     = r_i_err;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_done    = r_d_done;
    assign bus.d_err     = r_d_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Randomised transaction bench for mem_arbiter with a reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    logic last_own;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_req"},   bus.ram_req,   0);
        check({tag, "_ram_we"},    bus.ram_we,    0);
        check({tag, "_ram_be"},    bus.ram_be,    0);
        check({tag, "_ram_addr"},  bus.ram_addr,  0);
        check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
        check({tag, "_i_out"},     {bus.i_done, bus.i_err, bus.i_rdata}, 0);
        check({tag, "_d_out"},     {bus.d_done, bus.d_err, bus.d_rdata}, 0);
    endtask

    task automatic put_req(input logic port, input req_t r);
        if (port == OWN_D) begin
            bus.d_req = 1'b1; bus.d_we = r.we; bus.d_be = r.be;
            bus.d_addr = r.addr; bus.d_wdata = r.wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = r.addr;
        end
    endtask

    task automatic drop_req(input logic port);
        if (port == OWN_D) bus.d_req = 1'b0;
        else               bus.i_req = 1'b0;
    endtask

    // Called on the first negedge after the grant edge; ends on the IDLE negedge.
    task automatic do_access(input logic port, input req_t r, input int w, input logic [31:0] rd);
        bit          to;
        int          nbusy;
        logic [31:0] exp_rd;
        to     = (w >= TIMEOUT);
        nbusy  = to ? TIMEOUT : w + 1;
        exp_rd = (to || (port == OWN_D && r.we)) ? 32'h0 : rd;
        for (int j = 1; j <= nbusy; j++) begin
            check("busy_ram_req", bus.ram_req, 1);
            check("busy_ram_we",  bus.ram_we, (port == OWN_D) ? r.we : 1'b0);
            check("busy_ram_be",  bus.ram_be, (port == OWN_D) ? r.be : BE_ALL);
            check("busy_ram_addr", bus.ram_addr, r.addr);
            if (port == OWN_D) check("busy_ram_wdata", bus.ram_wdata, r.wdata);
            check("busy_no_done", {bus.i_done, bus.d_done}, 0);
            bus.ram_ready = (!to && j == w + 1);
            bus.ram_rdata = bus.ram_ready ? rd : $urandom;
            @(negedge clk);
        end
        bus.ram_ready = 1'b0;
        check("done_ram_req", bus.ram_req, 0);
        if (port == OWN_D) begin
            check("d_done",  bus.d_done, 1);
            check("d_err",   bus.d_err, to);
            check("d_rdata", bus.d_rdata, exp_rd);
            check("i_idle",  {bus.i_done, bus.i_err}, 0);
        end else begin
            check("i_done",  bus.i_done, 1);
            check("i_err",   bus.i_err, to);
            check("i_rdata", bus.i_rdata, exp_rd);
            check("d_idle",  {bus.d_done, bus.d_err}, 0);
        end
        drop_req(port);
        @(negedge clk);
        check("after_done", {bus.i_done, bus.d_done, bus.ram_req}, 0);
        check("after_addr", bus.ram_addr, 0);
    endtask

    // One or two requests; the late port (if any) arrives during the first access.
    task automatic run_pair(input bit have_i, input bit have_d, input bit late,
                            input logic late_port, input req_t rq [2], input int wt [2],
                            input logic [31:0] rdv [2]);
        bit   start_i, start_d;
        logic win;
        start_i = have_i && !(late && have_d && late_port == OWN_I);
        start_d = have_d && !(late && have_i && late_port == OWN_D);
        if (start_i || start_d) begin
            if (start_i) put_req(OWN_I, rq[0]);
            if (start_d) put_req(OWN_D, rq[1]);
            win      = (start_i && start_d) ? ~last_own : (start_d ? OWN_D : OWN_I);
            last_own = win;
            @(negedge clk);
            if (have_i && have_d && !(start_i && start_d)) put_req(~win, rq[~win]);
            do_access(win, rq[win], wt[win], rdv[win]);
            if (have_i && have_d) begin
                last_own = ~win;
                @(negedge clk);
                do_access(~win, rq[~win], wt[~win], rdv[~win]);
            end
        end
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 15)      return $urandom_range(0, 5);
        else if (r < 17) return TIMEOUT - 1;
        else             return TIMEOUT;
    endfunction

    req_t        rq  [2];
    int          wt  [2];
    logic [31:0] rdv [2];

    initial begin
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.ram_rdata = 0; bus.ram_ready = 0;
        last_own = OWN_I;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Tie straight after reset, then a second tie.
        rq[0] = '{addr: 32'h1000, we: 0, be: 4'hF, wdata: 0};
        rq[1] = '{addr: 32'h2000, we: 0, be: 4'hF, wdata: 0};
        wt[0] = 0; wt[1] = 1; rdv[0] = 32'h1111_0000; rdv[1] = 32'h2222_0000;
        run_pair(1, 1, 0, OWN_I, rq, wt, rdv);
        rq[0].addr = 32'h1004; rq[1].addr = 32'h2004;
        run_pair(1, 1, 0, OWN_I, rq, wt, rdv);

        // Zero-wait load.
        rq[1] = '{addr: 32'h100, we: 0, be: 4'hF, wdata: 0};
        wt[1] = 0; rdv[1] = 32'hCAFEF00D;
        run_pair(0, 1, 0, OWN_I, rq, wt, rdv);

        // Partial store with three RAM wait cycles.
        rq[1] = '{addr: 32'h40, we: 1, be: 4'b0011, wdata: 32'h12345678};
        wt[1] = 3; rdv[1] = 32'hDEAD_BEEF;
        run_pair(0, 1, 0, OWN_I, rq, wt, rdv);

        // Fetch that never completes, then one that answers on the last legal cycle.
        rq[0] = '{addr: 32'h0, we: 0, be: 4'hF, wdata: 0};
        wt[0] = TIMEOUT; rdv[0] = 32'h5555_AAAA;
        run_pair(1, 0, 0, OWN_I, rq, wt, rdv);
        wt[0] = TIMEOUT - 1;
        run_pair(1, 0, 0, OWN_I, rq, wt, rdv);

        // Data request arriving during a five-wait fetch must be served next.
        rq[0] = '{addr: 32'h80, we: 0, be: 4'hF, wdata: 0};
        rq[1] = '{addr: 32'hC0, we: 0, be: 4'hF, wdata: 0};
        wt[0] = 5; wt[1] = 0; rdv[0] = 32'hA5A5_0001; rdv[1] = 32'h5A5A_0002;
        run_pair(1, 1, 1, OWN_D, rq, wt, rdv);

        // Reset in the second BUSY cycle, then a stray ram_ready.
        put_req(OWN_D, '{addr: 32'h300, we: 0, be: 4'hF, wdata: 0});
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        drop_req(OWN_D);
        @(negedge clk);
        rst = 1'b0;
        last_own = OWN_I;
        bus.ram_ready = 1'b1; bus.ram_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.ram_ready = 1'b0;
        check("stray_ready_done", {bus.i_done, bus.d_done, bus.ram_req}, 0);
        @(negedge clk);
        check("stray_ready_done2", {bus.i_done, bus.d_done, bus.ram_req}, 0);

        for (int it = 0; it < 40; it++) begin
            int pat;
            pat = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                rq[p].addr  = $urandom;
                rq[p].we    = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                rq[p].be    = (p == 1) ? 4'($urandom_range(1, 15)) : 4'hF;
                rq[p].wdata = (p == 1) ? $urandom : 32'h0;
                wt[p]       = rand_wait();
                rdv[p]      = $urandom;
            end
            run_pair(pat[0], pat[1], ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                     rq, wt, rdv);
            if ($urandom_range(0, 1) == 1) begin
                bus.ram_ready = 1'b1; bus.ram_rdata = $urandom;
                @(negedge clk);
                bus.ram_ready = 1'b0;
                check("idle_ready_ignored", {bus.i_done, bus.d_done, bus.ram_req}, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between two requesters: instruction fetch (port I) and the memory stage's load/store path (port D).
- Sequences each access with a req/ready handshake to RAM, with variable RAM latency and a timeout abort.
- Returns read data and a one-cycle done pulse to the owning requester.
- Sits between the fetch/memory pipeline stages and the RAM model/controller.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 16, maximum BUSY cycles without ram_ready before abort; legal range is 2 to 255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch read data; valid while i_done=1.
- i_done  out  1  one-cycle completion pulse to fetch.
- i_err  out  1  timeout flag; qualified by i_done.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  byte enables for stores.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid while d_done=1.
- d_done  out  1  one-cycle completion pulse to data port.
- d_err  out  1  timeout flag; qualified by d_done.
- ram_req  out  1  access request to RAM.
- ram_we  out  1  write enable to RAM.
- ram_be  out  DATA_W/8  byte enables to RAM.
- ram_addr  out  ADDR_W  address to RAM.
- ram_wdata  out  DATA_W  write data to RAM.
- ram_rdata  in  DATA_W  RAM read data; valid when ram_ready=1.
- ram_ready  in  1  RAM completion; one cycle per access.

Behaviour:
- Reset (asynchronous): all outputs 0, state=IDLE, last_grant=I, timeout counter=0.
  - Reset during BUSY abandons the access immediately.
  - No done pulse is produced for an abandoned access.
- All outputs are registered. The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only one req high: grant it.
  - Both high: grant the port that is not last_grant (round-robin). After reset, D wins the first tie.
  - On grant: latch owner, addr, we, be and wdata into ram_* (fetch uses we=0, be=all ones), set ram_req=1, clear counter, update last_grant, go to BUSY.
- BUSY:
  - ram_req and the ram_* buses are held stable.
  - If ram_ready=1: capture ram_rdata into the owner's rdata, set the owner's done=1 and err=0, drop ram_req, go to DONE.
  - Else if counter == TIMEOUT-1: set the owner's done=1, err=1, rdata=0, drop ram_req, go to DONE.
  - Else increment the counter.
- DONE (lasts exactly one cycle):
  - The done pulse is visible during this cycle.
  - Next edge: clear done, err and the ram_* buses; go to IDLE.
  - Requests are not sampled in DONE.
- Requester rule: deassert req on the edge at which done=1 is sampled. A new request may be presented from the following cycle.
- Latency: request sampled at edge E0 → ram_req high after E0. With ram_ready=1 in that cycle, done is high after E1 (2 cycles minimum). Each RAM wait cycle adds 1.
- Stores: d_rdata is set to 0 on completion.
- ram_ready outside BUSY is ignored; no state change.
- A request arriving while the other port is owned waits; it is never dropped.
- The non-owner's done and err remain 0 throughout.
- Throughput: one access per 3 cycles when RAM has zero wait states.

Decomposition:
- Shared package mem_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - Owner encoding OWN_I=0, OWN_D=1.
  - Constant TO_W = $clog2(TIMEOUT).
  - Constant BE_ALL = all ones.
- One sub-module, rr_arb2: a 2-input round-robin grant with a last_grant register and an update strobe. The FSM, counter and buses stay in mem_arbiter.

Test Plan:
- Reset, then d_req=1, d_we=0, d_addr=0x100, RAM returns 0xCAFEF00D with 0 waits → ram_req high 1 cycle after; d_done=1 with d_rdata=0xCAFEF00D 2 cycles after the request; i_done stays 0.
- i_req and d_req asserted together in IDLE twice in a row → 1st grant D, 2nd grant I (round-robin).
- d store: d_addr=0x40, d_wdata=0x12345678, d_be=4'b0011, RAM 3 wait cycles → ram_we=1, ram_be=0011, stable for 4 BUSY cycles; d_done 1 cycle after ram_ready; d_rdata=0.
- i_req at 0x0 and RAM never ready, TIMEOUT=16 → i_done=1, i_err=1, i_rdata=0 exactly 16 BUSY cycles after grant; ram_req drops.
- rst asserted in the 2nd BUSY cycle → all outputs 0 asynchronously; after release, a spurious ram_ready pulse causes no done.
- d_req held during a 5-wait fetch → D granted in the IDLE cycle after i_done; no request lost.
